pw_verify_pipe: RTL
===================

# pw_verify_pipe

Parametrised, pipelined password verifier for the smart-lock datapath. It compares a keypad entry of `DIGITS` digits against a stored password from the register file. It reports the overall match, a per-digit miss mask and a one-cycle done pulse, and enforces a timed lockout after repeated failures. It sits between the keypad capture logic and the lock-control FSM and replaces the fixed 4×4-bit checker.

## Interface
- `DIGITS`, 4, number of password digits (≥1)
- `DIGIT_W`, 4, bits per digit (≥1)
- `MAX_FAILS`, 3, consecutive valid mismatches that trigger lockout (≥1)
- `LOCK_CYCLES`, 16, clk cycles the lockout lasts (≥1)
- `clk`  in  1  single clock; all state changes on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a check; sampled on posedge clk
- `entry`  in  DIGITS*DIGIT_W  keypad entry; digit i = bits [i*DIGIT_W +: DIGIT_W]
- `stored`  in  DIGITS*DIGIT_W  stored password, same packing
- `stored_valid`  in  1  stored password present (register-file available bit)
- `busy`  out  1  check in flight
- `done`  out  1  one-cycle pulse; result valid
- `match`  out  1  last result: all digits equal and stored_valid
- `no_pw`  out  1  last result was taken with stored_valid=0
- `miss_mask`  out  DIGITS  last result: bit i = 1 when digit i differs
- `fail_count`  out  $clog2(MAX_FAILS+1)  consecutive valid mismatches
- `locked`  out  1  lockout active; start ignored

## Operation
- Reset: every output is 0, the pipeline is flushed and the lock timer is 0. A reset during a check aborts it with no `done`.
- Accept: `start`=1 with `busy`=0 and `locked`=0 at a posedge. Otherwise `start` is dropped silently and is not queued.
- Stage S1 (accept edge E0): register `entry`, `stored`, `stored_valid`; `busy`←1.
- Stage S2 (E0+1): register the per-digit inequality vector.
- Stage S3 (E0+2), all registered together:
  - `miss_mask`←vector
  - `match`←(vector==0)&&valid
  - `no_pw`←~valid
  - `done`←1
  - `busy`←0
- `match`, `no_pw` and `miss_mask` hold until the next S3.
- `no_pw` forces `match`=0 and sets `miss_mask` to all ones. `fail_count` is unchanged.
- Valid mismatch: `fail_count`←`fail_count`+1.
  - On reaching `MAX_FAILS`: `locked`←1 and lock timer←`LOCK_CYCLES` on the same edge.
- Valid match: `fail_count`←0.
- Lock timer:
  - Decrements by 1 at each posedge while `locked`=1.
  - At the edge where the timer is 1: `locked`←0, `fail_count`←0, timer←0.
- `fail_count` never exceeds `MAX_FAILS`.
- `entry` and `stored` may change freely after E0; only the S1 copies are used.

## Timing
- Latency: `done` is high in the cycle after edge E0+2, i.e. 2 cycles after the accept edge. It is high for exactly 1 cycle.
- `busy` is high from E0 through E0+2, covering 2 cycles.
- Throughput: the earliest next accept is edge E0+3. A `start` held high continuously therefore yields one check every 3 cycles.
- `start` at E0+2 is ignored because `busy` is still 1 at that edge.
- `locked` rises at the S3 edge of the failing check, coincident with `done`. It stays high for exactly `LOCK_CYCLES` cycles.
- `start` while `locked`=1 produces no `busy` and no `done`.
- A `start` on the edge `locked` falls is ignored. The first accept is the following edge.
- `rst` wins over every simultaneous event.

## Test plan
Parameters: DIGITS=4, DIGIT_W=4, MAX_FAILS=3, LOCK_CYCLES=16.

- **Match:** `entry`=16'h1234, `stored`=16'h1234, `stored_valid`=1, `start` pulse at E0 -> `busy` high for 2 cycles; `done` pulse after E0+2 with `match`=1, `miss_mask`=4'b0000, `fail_count`=0.
- **Partial mismatch:** `entry`=16'h1934, `stored`=16'h1234 -> `match`=0, `miss_mask`=4'b0100, `fail_count`=1. A following correct entry -> `fail_count`=0.
- **Lockout:** three consecutive `entry`=16'h0000 against 16'h1234 -> third `done` coincides with `locked`=1 and `fail_count`=3. `start` pulses during the 16 locked cycles give no `done`. `locked`=0 and `fail_count`=0 after exactly 16 cycles; the next `start` is accepted.
- **No password:** `stored_valid`=0, `entry`=`stored`=16'h5555 -> `done`, `match`=0, `no_pw`=1, `miss_mask`=4'b1111, `fail_count` unchanged.
- **Busy drop / stability:**
  - `start` held high for 6 cycles -> exactly 2 `done` pulses, at E0+2 and E0+5.
  - Changing `entry` at E0+1 does not alter the first result.
- **Reset mid-check:** `rst` at E0+1 -> no `done` ever appears for that check. After the reset edge, `busy`=0, `match`=0, `miss_mask`=0, `locked`=0 and `fail_count`=0.

Source files
------------

// File: rtl/pw_verify_pipe.sv
// pw_verify_pipe: three-stage keypad password verifier
// with a consecutive-failure lockout timer.

module pw_capture_stage #(
   parameter int PW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          accept,
   input  logic [PW-1:0] entry,
   input  logic [PW-1:0] stored,
   input  logic          stored_valid,
   output logic          vld,
   output logic [PW-1:0] entry_q,
   output logic [PW-1:0] stored_q,
   output logic          valid_q
);

   // S1: snapshot operands so later input edits cannot leak in
   always_ff @(posedge clk) begin
      if (rst) begin
         vld      <= 1'b0;
         entry_q  <= '0;
         stored_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         vld <= accept;
         if (accept) begin
            entry_q  <= entry;
            stored_q <= stored;
            valid_q  <= stored_valid;
         end
      end
   end

endmodule

module pw_compare_stage #(
   parameter int DIGITS  = 4,
   parameter int DIGIT_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_vld,
   input  logic [DIGITS*DIGIT_W-1:0] entry_q,
   input  logic [DIGITS*DIGIT_W-1:0] stored_q,
   input  logic                      valid_q,
   output logic                      vld,
   output logic [DIGITS-1:0]         diff,
   output logic                      valid
);

   logic [DIGITS-1:0] diff_d;

   // Per-digit inequality of the captured operands
   always_comb begin
      diff_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
         diff_d[i] =
            entry_q[i*DIGIT_W +: DIGIT_W] !=
            stored_q[i*DIGIT_W +: DIGIT_W];
      end
   end

   // S2: register the inequality vector and its valid bit
   always_ff @(posedge clk) begin
      if (rst) begin
         vld   <= 1'b0;
         diff  <= '0;
         valid <= 1'b0;
      end else begin
         vld <= in_vld;
         if (in_vld) begin
            diff  <= diff_d;
            valid <= valid_q;
         end
      end
   end

endmodule

module pw_result_stage #(
   parameter int DIGITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   input  logic [DIGITS-1:0] diff,
   input  logic              valid,
   output logic              done,
   output logic              match,
   output logic              no_pw,
   output logic [DIGITS-1:0] miss_mask
);

   // S3: publish the verdict; it holds until the next check
   always_ff @(posedge clk) begin
      if (rst) begin
         done      <= 1'b0;
         match     <= 1'b0;
         no_pw     <= 1'b0;
         miss_mask <= '0;
      end else begin
         done <= in_vld;
         if (in_vld) begin
            match     <= valid && (diff == '0);
            no_pw     <= ~valid;
            miss_mask <= valid ? diff : '1;
         end
      end
   end

endmodule

module pw_lock_stage #(
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           chk_vld,
   input  logic                           chk_valid,
   input  logic                           chk_miss,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
   output logic                           locked
);

   localparam int FCW = $clog2(MAX_FAILS+1);
   localparam int TW  = $clog2(LOCK_CYCLES+1);
   localparam logic [FCW-1:0] FC_MAX = FCW'(MAX_FAILS);
   localparam logic [FCW-1:0] FC_ONE = FCW'(1);
   localparam logic [TW-1:0]  T_INIT = TW'(LOCK_CYCLES);
   localparam logic [TW-1:0]  T_ONE  = TW'(1);

   typedef enum logic {
      ST_OPEN,
      ST_LOCKED
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [TW-1:0]  timer_q;
   logic [FCW-1:0] fail_q;
   logic [FCW-1:0] fail_d;
   logic           bad;
   logic           good;
   logic           lock_hit;
   logic           unlock;
   logic           bump;

   assign bad  = chk_vld & chk_valid & chk_miss;
   assign good = chk_vld & chk_valid & ~chk_miss;

   assign lock_hit = bad && (fail_q == FC_MAX - FC_ONE);
   assign unlock   = (state_q == ST_LOCKED) &&
                     (timer_q == T_ONE);
   assign bump     = bad && !lock_hit &&
                     (fail_q != FC_MAX);

   // Lock state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_OPEN;
      else     state_q <= state_d;
   end

   // Lock next state: enter on the last allowed miss
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OPEN:   if (lock_hit) state_d = ST_LOCKED;
         ST_LOCKED: if (unlock)   state_d = ST_OPEN;
      endcase
   end

   // Lock outputs decoded from the state register
   always_comb begin
      locked = (state_q == ST_LOCKED);
   end

   // Lockout countdown; reaches zero on the unlock edge
   always_ff @(posedge clk) begin
      if (rst)
         timer_q <= '0;
      else if (lock_hit)
         timer_q <= T_INIT;
      else if (state_q == ST_LOCKED)
         timer_q <= timer_q - T_ONE;
   end

   // Next consecutive-miss count
   always_comb begin
      fail_d = fail_q;
      unique case (1'b1)
         lock_hit: fail_d = FC_MAX;
         unlock:   fail_d = '0;
         bump:     fail_d = fail_q + FC_ONE;
         good:     fail_d = '0;
         default:  fail_d = fail_q;
      endcase
   end

   // Consecutive-miss counter register
   always_ff @(posedge clk) begin
      if (rst) fail_q <= '0;
      else     fail_q <= fail_d;
   end

   assign fail_count = fail_q;

endmodule

module pw_verify_pipe #(
   parameter int DIGITS      = 4,
   parameter int DIGIT_W     = 4,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [DIGITS*DIGIT_W-1:0]      entry,
   input  logic [DIGITS*DIGIT_W-1:0]      stored,
   input  logic                           stored_valid,
   output logic                           busy,
   output logic                           done,
   output logic                           match,
   output logic                           no_pw,
   output logic [DIGITS-1:0]              miss_mask,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
   output logic                           locked
);

   localparam int PW = DIGITS * DIGIT_W;

   logic              accept;
   logic              s1_vld;
   logic [PW-1:0]     s1_entry;
   logic [PW-1:0]     s1_stored;
   logic              s1_valid;
   logic              s2_vld;
   logic [DIGITS-1:0] s2_diff;
   logic              s2_valid;

   assign accept = start & ~busy & ~locked;

   // busy spans the accept edge up to the result edge
   always_ff @(posedge clk) begin
      if (rst)         busy <= 1'b0;
      else if (accept) busy <= 1'b1;
      else if (s2_vld) busy <= 1'b0;
   end

   pw_capture_stage #(
      .PW (PW)
   ) u_capture (
      .clk          (clk),
      .rst          (rst),
      .accept       (accept),
      .entry        (entry),
      .stored       (stored),
      .stored_valid (stored_valid),
      .vld          (s1_vld),
      .entry_q      (s1_entry),
      .stored_q     (s1_stored),
      .valid_q      (s1_valid)
   );

   pw_compare_stage #(
      .DIGITS  (DIGITS),
      .DIGIT_W (DIGIT_W)
   ) u_compare (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (s1_vld),
      .entry_q  (s1_entry),
      .stored_q (s1_stored),
      .valid_q  (s1_valid),
      .vld      (s2_vld),
      .diff     (s2_diff),
      .valid    (s2_valid)
   );

   pw_result_stage #(
      .DIGITS (DIGITS)
   ) u_result (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (s2_vld),
      .diff      (s2_diff),
      .valid     (s2_valid),
      .done      (done),
      .match     (match),
      .no_pw     (no_pw),
      .miss_mask (miss_mask)
   );

   pw_lock_stage #(
      .MAX_FAILS   (MAX_FAILS),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) u_lock (
      .clk        (clk),
      .rst        (rst),
      .chk_vld    (s2_vld),
      .chk_valid  (s2_valid),
      .chk_miss   (|s2_diff),
      .fail_count (fail_count),
      .locked     (locked)
   );

endmodule
